snn_uart_seq: RTL and testbench
===============================

# snn_uart_seq

Frame sequencer between the UART receiver/transmitter pair and the SNN inference core. It collects one image frame of bytes from the UART receiver and writes them into the core's input memory. It then launches the core, waits for its result, and returns the classified digit to the host as one ASCII byte through the UART transmitter. It replaces the direct RX-to-TX loopback in the top level and owns all UART traffic sequencing.

## Interface
- IMG_BYTES, 98, bytes per frame (784 input bits packed 8 per byte, LSB = lowest pixel index)
- ADDR_W, 7, width of input-memory byte address; must satisfy 2^ADDR_W >= IMG_BYTES
- TIMEOUT, 2_604_000, idle cycles allowed between bytes of a partial frame before abort
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset; sampled on rising clk
- rx_rdy  input  1  one-cycle strobe, rx_data valid
- rx_data  input  8  received byte
- mem_we  output  1  input-memory write enable
- mem_addr  output  ADDR_W  input-memory byte address
- mem_wdata  output  8  input-memory write data
- core_start  output  1  one-cycle start pulse to SNN core
- core_done  input  1  one-cycle completion strobe from core
- core_result  input  4  classified digit 0-9, valid when core_done=1
- tx_start  output  1  one-cycle transmit request
- tx_data  output  8  byte to transmit; held stable from tx_start until return to IDLE
- tx_rdy  input  1  transmitter idle
- busy  output  1  high in every state except IDLE
- frame_err  output  1  sticky: partial frame aborted by timeout
- overrun  output  1  sticky: byte received while not accepting
- led  output  8  last transmitted result byte

## Operation
- States: IDLE, LOAD, START, WAIT_CORE, SEND, WAIT_TX.
- IDLE: byte counter = 0. On rx_rdy: write byte to address 0, counter := 1, clear frame_err and overrun, go to LOAD. If IMG_BYTES = 1, go to START instead.
- LOAD: on rx_rdy, write byte at address = counter and increment the counter. When the written byte is number IMG_BYTES-1, go to START. The timeout counter resets on every rx_rdy. If it reaches TIMEOUT with no rx_rdy, set frame_err and return to IDLE. Memory contents are left as written.
- START: assert core_start for exactly one cycle, then go to WAIT_CORE.
- WAIT_CORE: wait for core_done. On core_done, latch tx_data := 8'h30 + {4'h0, core_result}. A result above 9 is transmitted as 8'h3F ('?'). Go to SEND.
- SEND: stay until tx_rdy=1. In the first cycle with tx_rdy=1, assert tx_start for one cycle, load led := tx_data, and go to WAIT_TX.
- WAIT_TX: ignore tx_rdy in the first cycle after tx_start. Afterwards, return to IDLE when tx_rdy=1.
- rx_rdy in START, WAIT_CORE, SEND or WAIT_TX: the byte is dropped, overrun := 1, and there is no memory write.
- core_done outside WAIT_CORE is ignored.
- mem_we is asserted only in the cycle an accepted byte is written. mem_addr and mem_wdata are valid in that cycle only.

## Timing
- Reset values:
  - state = IDLE
  - all counters = 0
  - mem_we, core_start, tx_start, busy, frame_err, overrun = 0
  - mem_addr, mem_wdata = 0
  - tx_data = 8'h00, led = 8'h00
- Reset asserted mid-frame or mid-transmit abandons the operation immediately. There is no partial TX retry.
- Write latency: mem_we is registered and rises in the cycle after rx_rdy, with the matching address and data.
- core_start rises 1 cycle after the cycle that wrote the last byte (write cycle = N, START = N+1).
- tx_start rises 1 cycle after core_done if tx_rdy=1 at that time. Otherwise it rises 1 cycle after tx_rdy returns high.
- busy is combinational from state.
- Timeout boundary: abort in the cycle the idle count equals TIMEOUT. If rx_rdy arrives in that same cycle, the byte is accepted and the count is cleared, so there is no abort.

## Test plan
- Full frame: send 98 bytes 0x00..0x61, core_done with result=7 -> 98 writes at addresses 0..97 with matching data, one core_start, one tx_start with tx_data=0x37, led=0x37, busy low after tx_rdy returns.
- Timeout: send 40 bytes, then idle for TIMEOUT cycles -> frame_err=1, state IDLE, no core_start. Next frame's first byte clears frame_err.
- Overrun: send 1 extra byte during WAIT_CORE and 1 during WAIT_TX -> overrun=1, no mem_we, transaction completes normally.
- TX backpressure: hold tx_rdy=0 for 500 cycles after core_done with result=3 -> tx_start occurs exactly once, 1 cycle after tx_rdy rises, tx_data=0x33.
- Invalid result: core_result=12 -> tx_data=0x3F.
- Reset mid-LOAD: assert rst after 50 bytes -> all outputs return to reset values next cycle. A following full frame is written starting at address 0.

Source files
------------

// File: rtl/snn_uart_seq.sv
// snn_uart_seq: collects a UART frame into the SNN input memory, runs the core and returns the
// classified digit as one ASCII byte.
module snn_uart_seq #(
  parameter int IMG_BYTES = 98,
  parameter int ADDR_W    = 7,
  parameter int TIMEOUT   = 2_604_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_result,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic [7:0]        led
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_CORE, SEND, WAIT_TX} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [TW-1:0]     idle_cnt;
  logic              hold, wr, tmo, send;
  logic [7:0]        code;
  assign code = core_result > 4'd9 ? 8'h3F : 8'h30 + {4'h0, core_result};
  assign busy = state != IDLE;
  // tx_start is registered, so a ready transmitter is served straight from WAIT_CORE
  assign send = (state == WAIT_CORE && core_done && tx_rdy) || (state == SEND && tx_rdy);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    wr = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: if (rx_rdy) begin
        wr = 1'b1;
        state_n = IMG_BYTES == 1 ? START : LOAD;
      end
      LOAD: if (rx_rdy) begin
        wr = 1'b1;
        state_n = cnt == ADDR_W'(IMG_BYTES - 1) ? START : LOAD;
      end else if (idle_cnt == TW'(TIMEOUT)) begin
        tmo = 1'b1;
        state_n = IDLE;
      end
      START:     state_n = WAIT_CORE;
      WAIT_CORE: if (core_done) state_n = tx_rdy ? WAIT_TX : SEND;
      SEND:      if (tx_rdy) state_n = WAIT_TX;
      WAIT_TX:   if (tx_rdy && !tx_start && !hold) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt        <= '0;
      idle_cnt   <= '0;
      hold       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      led        <= 8'h00;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cnt        <= state_n == IDLE ? '0 : wr ? cnt + 1'b1 : cnt;
      idle_cnt   <= state == LOAD && !rx_rdy ? idle_cnt + 1'b1 : '0;
      hold       <= tx_start;
      mem_we     <= wr;
      mem_addr   <= wr ? cnt : '0;
      mem_wdata  <= wr ? rx_data : '0;
      core_start <= state == START;
      tx_start   <= send;
      if (state == WAIT_CORE && core_done) tx_data <= code;
      if (send) led <= state == WAIT_CORE ? code : tx_data;
      if (state == IDLE && rx_rdy) frame_err <= 1'b0;
      else if (tmo) frame_err <= 1'b1;
      if (state == IDLE && rx_rdy) overrun <= 1'b0;
      else if (rx_rdy && state != LOAD) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_snn_uart_seq.sv
// tb_snn_uart_seq: directed bench for the UART/SNN frame sequencer.
module tb_snn_uart_seq;
  localparam int N = 98;
  localparam int T = 20;
  logic       clk = 1'b0, rst = 1'b1, rx_rdy = 1'b0, core_done = 1'b0, tx_rdy = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] core_result = 4'h0;
  logic       mem_we, core_start, tx_start, busy, frame_err, overrun;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata, tx_data, led;
  int checks = 0, failures = 0;
  int n_cs = 0, n_ts = 0;
  logic [14:0] wq[$];

  snn_uart_seq #(.IMG_BYTES(N), .ADDR_W(7), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .tx_start(tx_start),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .busy(busy), .frame_err(frame_err),
    .overrun(overrun), .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (core_start) n_cs++;
    if (tx_start) n_ts++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fb(input int pat, input int i);
    logic [7:0] b;
    b = 8'(i);
    return pat == 0 ? b : pat == 1 ? b ^ 8'h5A : pat == 2 ? ~b : 8'(i * 3);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy = 1'b1;
    tick;
    rx_rdy = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int pat);
    for (int i = lo; i < hi; i++) send_byte(fb(pat, i));
  endtask

  task automatic chk_frame(input string tag, input int s, input int n, input int pat);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (s + i >= wq.size() || wq[s + i] !== {7'(i), fb(pat, i)}) bad++;
    chk({tag, "_count"}, wq.size() - s, n);
    chk({tag, "_data"}, bad, 0);
  endtask

  initial begin
    int s, cs0, ts0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_led", led, 8'h00);
    chk("rst_flags", {frame_err, overrun}, 0);
    rst = 1'b0;
    tick;

    // full frame, result 7, transmitter ready
    s = wq.size(); cs0 = n_cs; ts0 = n_ts;
    send_range(0, N, 0);
    chk("last_write_we", mem_we, 1);
    chk("last_write_addr", mem_addr, N - 1);
    chk("start_not_with_write", core_start, 0);
    tick;
    chk("core_start_pulse", core_start, 1);
    chk("mem_we_after_frame", mem_we, 0);
    core_result = 4'd7; core_done = 1'b1;
    tick;
    core_done = 1'b0;
    chk("core_start_one_cycle", core_start, 0);
    chk("tx_start_after_done", tx_start, 1);
    chk("tx_data_7", tx_data, 8'h37);
    chk("led_7", led, 8'h37);
    tx_rdy = 1'b0;
    tick;
    tick;
    tx_rdy = 1'b1;
    tick;
    chk("idle_after_tx", busy, 0);
    chk_frame("frame0", s, N, 0);
    chk("frame0_starts", n_cs - cs0, 1);
    chk("frame0_txs", n_ts - ts0, 1);

    // timeout: a gap of exactly T idle cycles is tolerated, T+1 aborts
    s = wq.size(); cs0 = n_cs;
    send_range(0, 40, 3);
    repeat (T) tick;
    chk("gap_T_no_abort", {busy, frame_err}, 2'b10);
    send_byte(fb(3, 40));
    chk("boundary_byte_we", mem_we, 1);
    chk("boundary_byte_addr", mem_addr, 40);
    repeat (T) tick;
    chk("before_abort", {busy, frame_err}, 2'b10);
    tick;
    chk("abort_frame_err", frame_err, 1);
    chk("abort_idle", busy, 0);
    chk_frame("partial", s, 41, 3);
    chk("partial_no_start", n_cs - cs0, 0);

    // overrun during WAIT_CORE and WAIT_TX, invalid result 12
    s = wq.size();
    send_byte(fb(1, 0));
    chk("first_byte_clears_ferr", frame_err, 0);
    send_range(1, N, 1);
    tick;
    tick;
    send_byte(8'hEE);
    chk("overrun_wait_core", overrun, 1);
    chk("overrun_no_we", mem_we, 0);
    core_result = 4'd12; core_done = 1'b1;
    tick;
    core_done = 1'b0;
    chk("tx_data_invalid", tx_data, 8'h3F);
    tx_rdy = 1'b0;
    send_byte(8'hEF);
    chk("overrun_wait_tx_no_we", mem_we, 0);
    tx_rdy = 1'b1;
    tick;
    chk("wait_tx_ignore_first", busy, 1);
    tick;
    chk("overrun_txn_done", busy, 0);
    chk("overrun_sticky", overrun, 1);
    chk("led_invalid", led, 8'h3F);
    chk_frame("frame1", s, N, 1);

    // transmitter backpressure, result 3
    send_byte(fb(0, 0));
    chk("first_byte_clears_ovr", overrun, 0);
    send_range(1, N, 0);
    tick;
    tick;
    tx_rdy = 1'b0;
    ts0 = n_ts;
    core_result = 4'd3; core_done = 1'b1;
    tick;
    core_done = 1'b0;
    repeat (500) tick;
    chk("bp_no_tx_start", n_ts - ts0, 0);
    chk("bp_busy", busy, 1);
    tx_rdy = 1'b1;
    tick;
    chk("bp_tx_start", tx_start, 1);
    chk("bp_tx_data", tx_data, 8'h33);
    tx_rdy = 1'b0;
    tick;
    tick;
    tx_rdy = 1'b1;
    tick;
    chk("bp_idle", busy, 0);
    chk("bp_single_tx", n_ts - ts0, 1);
    chk("bp_led", led, 8'h33);

    // reset in the middle of a frame
    send_range(0, 50, 2);
    rst = 1'b1;
    tick;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr_data", {mem_addr, mem_wdata}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_led_tx", {led, tx_data}, 0);
    rst = 1'b0;
    tick;
    s = wq.size();
    send_range(0, N, 2);
    tick;
    core_result = 4'd9; core_done = 1'b1;
    tick;
    core_done = 1'b0;
    chk("post_rst_tx_data", tx_data, 8'h39);
    tx_rdy = 1'b0;
    tick;
    tick;
    tx_rdy = 1'b1;
    tick;
    chk("post_rst_idle", busy, 0);
    chk_frame("frame_after_rst", s, N, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
